// File: rtl/gardner_ted_param_if.sv
// Sample/strobe input bundle and timing-error output for the Gardner detector.
interface gardner_ted_param_if #(
  parameter int WIDTH = 16
);
  logic                    clr;
  logic                    in_valid;
  logic signed [WIDTH-1:0] I_in;
  logic signed [WIDTH-1:0] Q_in;
  logic                    sym_strobe;
  logic                    mode;
  logic signed [WIDTH-1:0] err_out;
  logic                    err_valid;

  modport master (
    output clr, in_valid, I_in, Q_in, sym_strobe, mode,
    input  err_out, err_valid
  );

  modport slave (
    input  clr, in_valid, I_in, Q_in, sym_strobe, mode,
    output err_out, err_valid
  );
endinterface

// File: rtl/gardner_ted_param.sv
// Gardner timing-error detector with SPS-deep delay line and 2^AVG_LOG2 symbol averaging.
// Error valid 2 cycles after strobe (3 with GARDNER_FULL_MULT_EN, multiplier form); no backpressure.
module gardner_ted_param #(
  parameter int WIDTH    = 16,
  parameter int SPS      = 32,
  parameter int AVG_LOG2 = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  gardner_ted_param_if.slave ted
);
  localparam int HALF = SPS / 2;
  localparam int ACCW = WIDTH + AVG_LOG2;
  localparam int CNTW = AVG_LOG2 + 1;
  localparam int PCW  = $clog2(SPS + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'((1 << AVG_LOG2) - 1);

  typedef logic signed [WIDTH-1:0] samp_t;
  localparam samp_t S_MAX = samp_t'({1'b0, {(WIDTH-1){1'b1}}});
  localparam samp_t S_MIN = samp_t'({1'b1, {(WIDTH-1){1'b0}}});

  // Stored history only; the live input is x(n), so dl[SPS-1] is x(n-SPS).
  samp_t          dl_i_q [SPS];
  samp_t          dl_q_q [SPS];
  logic [PCW-1:0] prime_q;
  logic           primed;
  logic           fire;
  samp_t          mid_i, old_i, mid_q, old_q;

  assign primed = (prime_q == PCW'(SPS));
  assign fire   = ted.in_valid && ted.sym_strobe && !ted.clr && primed;
  assign mid_i  = dl_i_q[HALF-1];
  assign old_i  = dl_i_q[SPS-1];
  assign mid_q  = dl_q_q[HALF-1];
  assign old_q  = dl_q_q[SPS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prime_q <= '0;
      for (int k = 0; k < SPS; k++) begin
        dl_i_q[k] <= '0;
        dl_q_q[k] <= '0;
      end
    end else if (ted.clr) begin
      prime_q <= '0;
      for (int k = 0; k < SPS; k++) begin
        dl_i_q[k] <= '0;
        dl_q_q[k] <= '0;
      end
    end else if (ted.in_valid) begin
      if (!primed) prime_q <= prime_q + PCW'(1);
      dl_i_q[0] <= ted.I_in;
      dl_q_q[0] <= ted.Q_in;
      for (int k = 1; k < SPS; k++) begin
        dl_i_q[k] <= dl_i_q[k-1];
        dl_q_q[k] <= dl_q_q[k-1];
      end
    end
  end

  // Per-channel errors entering the combine/average stage.
  logic  e1_vld_q, e1_mode_q;
  samp_t e1_i_q, e1_q_q;

`ifdef GARDNER_FULL_MULT_EN
  localparam int PW = 2 * WIDTH + 1;
  typedef logic signed [PW-1:0] prod_t;
  typedef logic signed [WIDTH:0] diff_t;

  function automatic prod_t mult_err(samp_t cur, samp_t mid, samp_t old);
    diff_t d;
    d = diff_t'(cur) - diff_t'(old);
    return prod_t'(mid) * prod_t'(d);
  endfunction

  function automatic samp_t sat_scale(prod_t p);
    prod_t s;
    s = p >>> (WIDTH - 1);
    if (s > prod_t'(S_MAX)) return S_MAX;
    if (s < prod_t'(S_MIN)) return S_MIN;
    return s[WIDTH-1:0];
  endfunction

  logic  p_vld_q, p_mode_q;
  prod_t p_i_q, p_q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_vld_q  <= 1'b0;
      p_mode_q <= 1'b0;
      p_i_q    <= '0;
      p_q_q    <= '0;
    end else begin
      p_vld_q <= fire;
      if (fire) begin
        p_mode_q <= ted.mode;
        p_i_q    <= mult_err(ted.I_in, mid_i, old_i);
        p_q_q    <= mult_err(ted.Q_in, mid_q, old_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e1_vld_q  <= 1'b0;
      e1_mode_q <= 1'b0;
      e1_i_q    <= '0;
      e1_q_q    <= '0;
    end else begin
      e1_vld_q <= p_vld_q && !ted.clr;
      if (p_vld_q) begin
        e1_mode_q <= p_mode_q;
        e1_i_q    <= sat_scale(p_i_q);
        e1_q_q    <= sat_scale(p_q_q);
      end
    end
  end
`else
  // Sign form: only a sign change between old and cur contributes, weighted by mid.
  function automatic samp_t sign_err(samp_t cur, samp_t mid, samp_t old);
    samp_t r;
    r = '0;
    if (!cur[WIDTH-1] && old[WIDTH-1]) r = mid;
    else if (cur[WIDTH-1] && !old[WIDTH-1]) r = (mid == S_MIN) ? S_MAX : -mid;
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e1_vld_q  <= 1'b0;
      e1_mode_q <= 1'b0;
      e1_i_q    <= '0;
      e1_q_q    <= '0;
    end else begin
      e1_vld_q <= fire;
      if (fire) begin
        e1_mode_q <= ted.mode;
        e1_i_q    <= sign_err(ted.I_in, mid_i, old_i);
        e1_q_q    <= sign_err(ted.Q_in, mid_q, old_q);
      end
    end
  end
`endif

  samp_t                  e_comb;
  logic signed [ACCW-1:0] acc_q, acc_d, acc_sum;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  samp_t                  err_out_q, err_out_d;
  logic                   err_valid_q, err_valid_d;

  // Halving each channel before the add keeps the QPSK sum inside WIDTH.
  assign e_comb  = e1_mode_q ? samp_t'((e1_i_q >>> 1) + (e1_q_q >>> 1)) : e1_i_q;
  assign acc_sum = acc_q + ACCW'(e_comb);

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    err_out_d   = err_out_q;
    err_valid_d = 1'b0;
    if (ted.clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (e1_vld_q) begin
      if (cnt_q == CNT_LAST) begin
        err_out_d   = samp_t'(acc_sum >>> AVG_LOG2);
        err_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      err_out_q   <= '0;
      err_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      err_out_q   <= err_out_d;
      err_valid_q <= err_valid_d;
    end
  end

  assign ted.err_out   = err_out_q;
  assign ted.err_valid = err_valid_q;
endmodule

// File: tb/tb_gardner_ted_param.sv
// Bench: directed Gardner cases plus random streams against a queue-based reference model.
module tb_gardner_ted_param;
  localparam int W   = 16;
  localparam int SPS = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                clr, in_valid, sym_strobe, mode;
  logic signed [W-1:0] I_in, Q_in;

  gardner_ted_param_if #(.WIDTH(W)) if0 ();
  gardner_ted_param_if #(.WIDTH(W)) if2 ();

  assign if0.clr = clr;           assign if2.clr = clr;
  assign if0.in_valid = in_valid; assign if2.in_valid = in_valid;
  assign if0.I_in = I_in;         assign if2.I_in = I_in;
  assign if0.Q_in = Q_in;         assign if2.Q_in = Q_in;
  assign if0.sym_strobe = sym_strobe; assign if2.sym_strobe = sym_strobe;
  assign if0.mode = mode;         assign if2.mode = mode;

  gardner_ted_param #(.WIDTH(W), .SPS(SPS), .AVG_LOG2(0)) dut0 (.clk(clk), .rst_n(rst_n), .ted(if0));
  gardner_ted_param #(.WIDTH(W), .SPS(SPS), .AVG_LOG2(2)) dut2 (.clk(clk), .rst_n(rst_n), .ted(if2));

  typedef struct { int due; int val; } pend_t;
  int    hist_i[$], hist_q[$];  // newest sample at index 0
  pend_t pend0[$], pend2[$];
  int    step_no = 0;
  int    last0 = 0, last2 = 0, sum2 = 0, cnt2 = 0;
  int    vld0_seen = 0, vld2_seen = 0;
  int    n_checks = 0, n_fail = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int gerr(int cur, int mid, int old);
    if (cur >= 0 && old < 0) return mid;
    if (cur < 0 && old >= 0) return (mid == -32768) ? 32767 : -mid;
    return 0;
  endfunction

  function automatic int rnd_s();
    logic [15:0] r;
    r = 16'($urandom);
    if ($urandom_range(0, 15) == 0) r = 16'h8000;
    return int'($signed(r));
  endfunction

  task automatic model_reset();
    hist_i.delete(); hist_q.delete();
    pend0.delete(); pend2.delete();
    sum2 = 0; cnt2 = 0;
  endtask

  task automatic check_out();
    logic ev0, ev2;
    ev0 = 1'b0;
    ev2 = 1'b0;
    if (pend0.size() > 0 && pend0[0].due == step_no) begin
      ev0 = 1'b1; last0 = pend0[0].val; void'(pend0.pop_front());
    end
    if (pend2.size() > 0 && pend2[0].due == step_no) begin
      ev2 = 1'b1; last2 = pend2[0].val; void'(pend2.pop_front());
    end
    if (if0.err_valid === 1'b1) vld0_seen++;
    if (if2.err_valid === 1'b1) vld2_seen++;
    chk("vld_avg1", if0.err_valid, ev0);
    chk("out_avg1", if0.err_out, last0);
    chk("vld_avg4", if2.err_valid, ev2);
    chk("out_avg4", if2.err_out, last2);
  endtask

  task automatic step(input logic v, input int i, input int q, input logic s, input logic m, input logic c);
    int e;
    in_valid = v; I_in = 16'(i); Q_in = 16'(q); sym_strobe = s; mode = m; clr = c;
    @(posedge clk);
    step_no++;
    if (c) begin
      while (pend0.size() > 0 && pend0[$].due >= step_no) void'(pend0.pop_back());
      while (pend2.size() > 0 && pend2[$].due >= step_no) void'(pend2.pop_back());
      hist_i.delete(); hist_q.delete();
      sum2 = 0; cnt2 = 0;
    end else if (v) begin
      if (s && hist_i.size() == SPS) begin
        e = m ? ((gerr(i, hist_i[SPS/2-1], hist_i[SPS-1]) >>> 1) +
                 (gerr(q, hist_q[SPS/2-1], hist_q[SPS-1]) >>> 1))
              : gerr(i, hist_i[SPS/2-1], hist_i[SPS-1]);
        pend0.push_back('{step_no + 1, e});
        sum2 += e;
        cnt2++;
        if (cnt2 == 4) begin
          pend2.push_back('{step_no + 1, sum2 >>> 2});
          sum2 = 0; cnt2 = 0;
        end
      end
      hist_i.push_front(i); hist_q.push_front(q);
      if (hist_i.size() > SPS) begin
        void'(hist_i.pop_back()); void'(hist_q.pop_back());
      end
    end
    #1;
    check_out();
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Eight samples placing old at x(n-8) and mid at x(n-4), then the strobed current sample.
  task automatic sym(input int io, input int im, input int ic, input int qo, input int qm, input int qc, input logic m);
    for (int k = 0; k < SPS; k++)
      step(1'b1, (k == 0) ? io : (k == 4) ? im : 0, (k == 0) ? qo : (k == 4) ? qm : 0, 1'b0, m, 1'b0);
    step(1'b1, ic, qc, 1'b1, m, 1'b0);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_vld_avg1", if0.err_valid, 0);
    chk("rst_out_avg1", if0.err_out, 0);
    chk("rst_vld_avg4", if2.err_valid, 0);
    chk("rst_out_avg4", if2.err_out, 0);
    model_reset();
    last0 = 0; last2 = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int base0, base2;
    clr = 1'b0; in_valid = 1'b0; I_in = '0; Q_in = '0; sym_strobe = 1'b0; mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_vld", if0.err_valid, 0);
    chk("init_out", if0.err_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // BPSK transition
    sym(-1000, 500, 1000, 0, 0, 0, 1'b0);
    chk("bpsk_early_vld", if0.err_valid, 0);
    idle();
    chk("bpsk_vld", if0.err_valid, 1);
    chk("bpsk_out", if0.err_out, 500);

    // QPSK: Q flat, then Q mirrors I
    sym(-1000, 500, 1000, 800, 300, 800, 1'b1);
    idle();
    chk("qpsk_flat_out", if0.err_out, 250);
    sym(-1000, 500, 1000, -1000, 500, 1000, 1'b1);
    idle();
    chk("qpsk_mirror_out", if0.err_out, 500);

    // Negating the most negative mid saturates
    sym(5, -32768, -5, 0, 0, 0, 1'b0);
    idle();
    chk("sat_out", if0.err_out, 32767);

    // Average of four: 100, 200, 300, -200 -> 100
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    base2 = vld2_seen;
    sym(-1, 100, 1, 0, 0, 0, 1'b0);
    sym(-1, 200, 1, 0, 0, 0, 1'b0);
    sym(-1, 300, 1, 0, 0, 0, 1'b0);
    sym(-1, -200, 1, 0, 0, 0, 1'b0);
    idle();
    chk("avg_pulses", vld2_seen - base2, 1);
    chk("avg_out", if2.err_out, 100);

    // Random streams with sporadic clr
    for (int n = 0; n < 300; n++) begin
      step($urandom_range(0, 9) < 8, rnd_s(), rnd_s(), $urandom_range(0, 3) == 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0);
    end

    // Reset mid-stream, then strobes on every sample while re-priming
    do_reset();
    base0 = vld0_seen;
    for (int n = 0; n < SPS; n++) step(1'b1, -2000 + n, 0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("reprime_no_vld", vld0_seen - base0, 0);
    step(1'b1, 3000, 0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("reprime_first_vld", vld0_seen - base0, 1);

    // Strobe on 5th sample after reset is ignored
    do_reset();
    base0 = vld0_seen;
    for (int n = 0; n < 4; n++) step(1'b1, -700, 0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 700, 0, 1'b1, 1'b0, 1'b0);
    idle(); idle();
    chk("early_strobe_no_vld", vld0_seen - base0, 0);

    // Strobe coinciding with clr is dropped
    for (int n = 0; n < SPS; n++) step(1'b1, (n == 0) ? -900 : 450, 0, 1'b0, 1'b0, 1'b0);
    base0 = vld0_seen;
    step(1'b1, 900, 0, 1'b1, 1'b0, 1'b1);
    idle(); idle();
    chk("clr_strobe_no_vld", vld0_seen - base0, 0);
    chk("clr_holds_out", if0.err_out, last0);

    for (int n = 0; n < 150; n++) begin
      step($urandom_range(0, 9) < 9, rnd_s(), rnd_s(), $urandom_range(0, 1) == 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 79) == 0);
    end
    idle(); idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
